// File: rtl/seq_divider_pkg.sv
// Shared widths, iteration count, FSM state type and result record for the
// sequential restoring divider.
package seq_divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int PREM_W     = DIVISOR_W + 1;
    localparam int ITERS      = 8;
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIVIDEND_W-1:0] quotient;
        logic [DIVISOR_W-1:0]  remainder;
        logic                  dbz;
    } div_result_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference if it did not go negative.
module div_step
    import seq_divider_pkg::*;
(
    input  logic [PREM_W-1:0]    prem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [PREM_W-1:0]    prem_next,
    output logic                 qbit
);

    logic [PREM_W:0] shifted;

    // prem is always below the divisor, so the shifted value fits in PREM_W bits
    assign shifted   = {prem, bit_in};
    assign qbit      = (shifted >= {2'b00, divisor});
    assign prem_next = qbit ? PREM_W'(shifted - {2'b00, divisor}) : PREM_W'(shifted);

endmodule

// File: rtl/seq_divider.sv
// 8-by-4 unsigned sequential divider: one quotient bit per cycle, MSB first,
// with a fast path for divide-by-zero. Only built for 8/4 widths.
module seq_divider #(
    parameter int DIVIDEND_W = seq_divider_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = seq_divider_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz
);
    import seq_divider_pkg::*;

    state_t                state;
    logic [DIVIDEND_W-1:0] shreg;
    logic [DIVISOR_W-1:0]  dvs;
    logic [PREM_W-1:0]     prem;
    logic [PREM_W-1:0]     prem_next;
    logic [CNT_W-1:0]      cnt;
    logic                  qbit;
    div_result_t           res;

    // shreg feeds dividend bits out of the top while quotient bits enter at the bottom
    div_step u_step (
        .prem      (prem),
        .bit_in    (shreg[DIVIDEND_W-1]),
        .divisor   (dvs),
        .prem_next (prem_next),
        .qbit      (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            dvs   <= '0;
            prem  <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            shreg <= dividend;
                            dvs   <= divisor;
                            prem  <= '0;
                            cnt   <= '0;
                            state <= ST_RUN;
                        end else begin
                            res.quotient  <= '1;
                            res.remainder <= dividend[DIVISOR_W-1:0];
                            res.dbz       <= 1'b1;
                            state         <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    prem  <= prem_next;
                    shreg <= {shreg[DIVIDEND_W-2:0], qbit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        res.quotient  <= {shreg[DIVIDEND_W-2:0], qbit};
                        res.remainder <= prem_next[DIVISOR_W-1:0];
                        res.dbz       <= 1'b0;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign quotient  = res.quotient;
    assign remainder = res.remainder;
    assign dbz       = res.dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, exhaustive operand sweep
// and randomized runs with start noise, against an arithmetic reference.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       ready, busy, done, dbz;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " ready"}, 32'(ready), 1);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " q"}, 32'(quotient), 0);
        chk({tag, " r"}, 32'(remainder), 0);
        chk({tag, " dbz"}, 32'(dbz), 0);
    endtask

    // Runs one division. noise: random start/operand toggling while busy.
    // inject_at: wait-cycle index at which to pulse start with 9/3 (0 = never).
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit noise, input int inject_at);
        int          cyc;
        int          exp_lat;
        logic [7:0]  exp_q;
        logic [3:0]  exp_r;
        logic        exp_z;
        string       op;
        op      = $sformatf("%0d/%0d", a, b);
        exp_z   = (b == 0);
        exp_q   = exp_z ? 8'hFF : 8'(int'(a) / int'(b));
        exp_r   = exp_z ? a[3:0] : 4'(int'(a) % int'(b));
        exp_lat = exp_z ? 1 : 9;

        @(negedge clk);
        chk({op, " ready_pre"}, 32'(ready), 1);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
        cyc = 1;
        if (!exp_z) chk({op, " busy"}, 32'(busy), 1);
        while (!done && cyc < 20) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                dividend = 8'($urandom); divisor = 4'($urandom);
            end else if (cyc == inject_at) begin
                start = 1'b1; dividend = 8'd9; divisor = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({op, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({op, " done"}, 32'(done), 1);
        chk({op, " q"}, 32'(quotient), 32'(exp_q));
        chk({op, " r"}, 32'(remainder), 32'(exp_r));
        chk({op, " dbz"}, 32'(dbz), 32'(exp_z));
        @(negedge clk);
        chk({op, " done_pulse"}, 32'(done), 0);
        chk({op, " ready_post"}, 32'(ready), 1);
        chk({op, " q_hold"}, 32'(quotient), 32'(exp_q));
        chk({op, " r_hold"}, 32'(remainder), 32'(exp_r));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        // start held high during reset must be ignored
        start = 1'b1; dividend = 8'd50; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        chk_reset_state("reset");

        run_op(8'd200, 4'd7, 1'b0, 0);
        run_op(8'd225, 4'd15, 1'b0, 0);
        run_op(8'd255, 4'd1, 1'b0, 0);
        run_op(8'd0, 4'd5, 1'b0, 0);
        run_op(8'd100, 4'd0, 1'b0, 0);
        run_op(8'd200, 4'd7, 1'b0, 3);

        // reset in the middle of RUN abandons the operation
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrst");
        repeat (10) @(negedge clk);
        chk("midrst no_done", 32'(done), 0);
        chk("midrst idle", 32'(ready), 1);
        run_op(8'd81, 4'd9, 1'b0, 0);

        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                run_op(8'(a), 4'(b), 1'b0, 0);

        for (int i = 0; i < 200; i++)
            run_op(8'($urandom), 4'($urandom), 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
